// File: rtl/mul_pipe_pkg.sv
// Shared multiplier constants: function encodings, pipeline depth and
// small decode helpers used by the execute-stage multiplier.
package mul_pipe_pkg;

  // Number of register stages between acceptance and result presentation;
  // the issue logic schedules writeback with it.
  localparam int MUL_PIPE_DEPTH = 4;

  typedef enum logic [3:0] {
    FN_MUL    = 4'd0,
    FN_MULH   = 4'd1,
    FN_MULHSU = 4'd2,
    FN_MULHU  = 4'd3
  } mul_func_e;

  // rs1 is treated as signed for MUL, MULH and MULHSU.
  function automatic logic func_a_signed(input logic [3:0] func);
    return (func == FN_MUL) || (func == FN_MULH) || (func == FN_MULHSU);
  endfunction

  // rs2 is treated as signed for MUL and MULH.
  function automatic logic func_b_signed(input logic [3:0] func);
    return (func == FN_MUL) || (func == FN_MULH);
  endfunction

  // The three high-half variants return the upper XLEN bits of the product.
  function automatic logic func_takes_high(input logic [3:0] func);
    return (func == FN_MULH) || (func == FN_MULHSU) || (func == FN_MULHU);
  endfunction

endpackage

// File: rtl/mul_pipe_if.sv
// Request/result bundle between the issue logic (master) and mul_pipe (slave).
//
// Handshake: a request is accepted on a rising edge where mul_valid_i,
// mul_ready_o are both 1 and flush_i is 0. A result is consumed on a rising
// edge where mul_res_valid_o and mul_res_ready_i are both 1; while the
// consumer holds mul_res_ready_i low the presented result and tag do not
// change. flush_i kills everything in flight and any request that cycle.
interface mul_pipe_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
);
  import mul_pipe_pkg::*;

  logic [XLEN-1:0]  opr_a_i;
  logic [XLEN-1:0]  opr_b_i;
  logic             mul_valid_i;
  logic [3:0]       mul_func_i;
  logic             word_op_i;
  logic [TAG_W-1:0] mul_tag_i;
  logic             mul_ready_o;
  logic             flush_i;
  logic             mul_res_ready_i;
  logic [XLEN-1:0]  mul_res_o;
  logic [TAG_W-1:0] mul_res_tag_o;
  logic             mul_res_valid_o;
  logic             mul_busy_o;

  modport master (
    output opr_a_i, opr_b_i, mul_valid_i, mul_func_i, word_op_i, mul_tag_i,
    output flush_i, mul_res_ready_i,
    input  mul_ready_o, mul_res_o, mul_res_tag_o, mul_res_valid_o, mul_busy_o
  );

  modport slave (
    input  opr_a_i, opr_b_i, mul_valid_i, mul_func_i, word_op_i, mul_tag_i,
    input  flush_i, mul_res_ready_i,
    output mul_ready_o, mul_res_o, mul_res_tag_o, mul_res_valid_o, mul_busy_o
  );

endinterface

// File: rtl/mul_pipe_operand_mag.sv
// Operand conditioning: unsigned magnitude and effective sign of one operand.
// For word ops only the low 32 bits count, always as signed, and the upper
// magnitude half is zero. The most-negative value maps to 2^(n-1), which is
// exact as an unsigned magnitude, so it needs no special case.
module mul_operand_mag
  import mul_pipe_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] opr,
  input  logic            is_signed,
  input  logic            word_op,
  output logic [XLEN-1:0] mag,
  output logic            is_neg
);

  logic [31:0] word_lo;
  logic [31:0] word_mag;

  // Select between the 32-bit signed word view and the full-width view.
  always_comb begin
    word_lo  = opr[31:0];
    word_mag = word_lo[31] ? (~word_lo + 32'd1) : word_lo;
    if (word_op) begin
      is_neg = word_lo[31];
      mag    = XLEN'(word_mag);
    end else begin
      is_neg = opr[XLEN-1] & is_signed;
      mag    = is_neg ? (~opr + XLEN'(1)) : opr;
    end
  end

endmodule

// File: rtl/mul_pipe.sv
// Four-stage pipelined RV M-extension multiplier with tags, global stall on
// result backpressure and a flush that kills all in-flight operations.
module mul_pipe
  import mul_pipe_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic           clk,
  input  logic           reset,
  mul_pipe_if.slave      bus
);

  localparam int H   = XLEN / 2;
  localparam int W2  = 2 * XLEN;
  localparam int XP1 = XLEN + 1;

  // Stage 1: magnitudes and sign
  logic             s1_valid, s1_neg, s1_word;
  logic [TAG_W-1:0] s1_tag;
  logic [3:0]       s1_func;
  logic [XLEN-1:0]  s1_a_mag, s1_b_mag;
  // Stage 2: partial products
  logic             s2_valid, s2_neg, s2_word;
  logic [TAG_W-1:0] s2_tag;
  logic [3:0]       s2_func;
  logic [XLEN-1:0]  s2_p0, s2_p1, s2_p2, s2_p3;
  // Stage 3: partial sum plus the untouched high-high product
  logic             s3_valid, s3_neg, s3_word;
  logic [TAG_W-1:0] s3_tag;
  logic [3:0]       s3_func;
  logic [W2-1:0]    s3_psum;
  logic [XLEN-1:0]  s3_p3;
  // Stage 4: selected result
  logic             s4_valid;
  logic [TAG_W-1:0] s4_tag;
  logic [XLEN-1:0]  s4_res;

  logic            word_eff, advance, accept;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN-1:0] p0_d, p1_d, p2_d, p3_d;
  logic [XP1-1:0]  cross_d;
  logic [W2-1:0]   psum_d, full_d, signed_full_d;
  logic [XLEN-1:0] res_d;

  // MULW only exists on 64-bit builds.
  assign word_eff = (XLEN == 64) & bus.word_op_i;

  mul_operand_mag #(.XLEN(XLEN)) u_mag_a (
    .opr       (bus.opr_a_i),
    .is_signed (func_a_signed(bus.mul_func_i)),
    .word_op   (word_eff),
    .mag       (a_mag),
    .is_neg    (a_neg)
  );

  mul_operand_mag #(.XLEN(XLEN)) u_mag_b (
    .opr       (bus.opr_b_i),
    .is_signed (func_b_signed(bus.mul_func_i)),
    .word_op   (word_eff),
    .mag       (b_mag),
    .is_neg    (b_neg)
  );

  // Global stall: everything holds while a presented result is refused.
  assign advance         = ~(s4_valid & ~bus.mul_res_ready_i);
  assign bus.mul_ready_o = advance & ~reset;
  assign accept          = bus.mul_valid_i & bus.mul_ready_o & ~bus.flush_i;

  // Half-width partial products from the stage-1 magnitudes.
  always_comb begin
    p0_d = XLEN'(s1_a_mag[H-1:0]) * XLEN'(s1_b_mag[H-1:0]);
    p1_d = XLEN'(s1_a_mag[H-1:0]) * XLEN'(s1_b_mag[XLEN-1:H]);
    p2_d = XLEN'(s1_a_mag[XLEN-1:H]) * XLEN'(s1_b_mag[H-1:0]);
    p3_d = XLEN'(s1_a_mag[XLEN-1:H]) * XLEN'(s1_b_mag[XLEN-1:H]);
  end

  // Low partial sum; the cross sum needs one extra bit for its carry.
  always_comb begin
    cross_d = XP1'(s2_p1) + XP1'(s2_p2);
    psum_d  = W2'(s2_p0) + (W2'(cross_d) << H);
  end

  // Full product, sign restore and result selection.
  always_comb begin
    full_d        = s3_psum + {s3_p3, {XLEN{1'b0}}};
    signed_full_d = s3_neg ? (~full_d + W2'(1)) : full_d;
    if (s3_word) begin
      res_d = XLEN'($signed(signed_full_d[31:0]));
    end else if (s3_func == FN_MUL) begin
      res_d = signed_full_d[XLEN-1:0];
    end else if (func_takes_high(s3_func)) begin
      res_d = signed_full_d[W2-1:XLEN];
    end else begin
      res_d = '0;
    end
  end

  // Stage registers: reset clears all, flush kills valids, else shift on advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0; s1_neg <= 1'b0; s1_word <= 1'b0; s1_tag <= '0;
      s1_func  <= '0;   s1_a_mag <= '0; s1_b_mag <= '0;
      s2_valid <= 1'b0; s2_neg <= 1'b0; s2_word <= 1'b0; s2_tag <= '0;
      s2_func  <= '0;   s2_p0 <= '0; s2_p1 <= '0; s2_p2 <= '0; s2_p3 <= '0;
      s3_valid <= 1'b0; s3_neg <= 1'b0; s3_word <= 1'b0; s3_tag <= '0;
      s3_func  <= '0;   s3_psum <= '0; s3_p3 <= '0;
      s4_valid <= 1'b0; s4_tag <= '0; s4_res <= '0;
    end else if (bus.flush_i) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s4_valid <= 1'b0;
    end else if (advance) begin
      s1_valid <= accept;
      s1_neg   <= a_neg ^ b_neg;
      s1_word  <= word_eff;
      s1_tag   <= bus.mul_tag_i;
      s1_func  <= bus.mul_func_i;
      s1_a_mag <= a_mag;
      s1_b_mag <= b_mag;
      s2_valid <= s1_valid; s2_neg <= s1_neg; s2_word <= s1_word;
      s2_tag   <= s1_tag;   s2_func <= s1_func;
      s2_p0    <= p0_d; s2_p1 <= p1_d; s2_p2 <= p2_d; s2_p3 <= p3_d;
      s3_valid <= s2_valid; s3_neg <= s2_neg; s3_word <= s2_word;
      s3_tag   <= s2_tag;   s3_func <= s2_func;
      s3_psum  <= psum_d;   s3_p3 <= s2_p3;
      s4_valid <= s3_valid;
      s4_tag   <= s3_tag;
      s4_res   <= res_d;
    end
  end

  assign bus.mul_res_o       = s4_res;
  assign bus.mul_res_tag_o   = s4_tag;
  assign bus.mul_res_valid_o = s4_valid & ~bus.flush_i;
  assign bus.mul_busy_o      = s1_valid | s2_valid | s3_valid | s4_valid;

endmodule

// File: tb/tb_mul_pipe.sv
// Bench for mul_pipe: 64-bit instance checked by a scoreboard fed from a
// wide-integer product model, plus a 32-bit instance with directed checks.
module tb_mul_pipe;
  import mul_pipe_pkg::*;

  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  logic [TAG_W+63:0] exp_q[$];

  mul_pipe_if #(.XLEN(64), .TAG_W(TAG_W)) bus ();
  mul_pipe_if #(.XLEN(32), .TAG_W(TAG_W)) bus32 ();

  mul_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  mul_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus32.slave)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  // Exact signed/unsigned product in a wide integer, then the architectural
  // result selection.
  function automatic logic [63:0] model(input int xl, input logic [63:0] a,
                                        input logic [63:0] b, input logic [3:0] f,
                                        input logic w);
    logic signed [131:0] ea, eb, prod;
    logic [63:0] mask;
    logic [31:0] lo32;
    logic        a_s, b_s;
    mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    if (w && xl == 64) begin
      ea   = 132'($signed(a[31:0]));
      eb   = 132'($signed(b[31:0]));
      prod = ea * eb;
      lo32 = prod[31:0];
      return {{32{lo32[31]}}, lo32};
    end
    a_s = (f == FN_MUL) || (f == FN_MULH) || (f == FN_MULHSU);
    b_s = (f == FN_MUL) || (f == FN_MULH);
    ea = 132'(a & mask);
    eb = 132'(b & mask);
    if (a_s && a[xl-1]) ea = ea - (132'sd1 << xl);
    if (b_s && b[xl-1]) eb = eb - (132'sd1 << xl);
    prod = ea * eb;
    case (f)
      FN_MUL:                      return 64'(prod) & mask;
      FN_MULH, FN_MULHSU, FN_MULHU: return 64'(prod >> xl) & mask;
      default:                     return 64'd0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [3:0] f,
                       input logic w, input logic [TAG_W-1:0] t);
    bus.opr_a_i     = a;
    bus.opr_b_i     = b;
    bus.mul_func_i  = f;
    bus.word_op_i   = w;
    bus.mul_tag_i   = t;
    bus.mul_valid_i = 1'b1;
  endtask

  task automatic idle();
    bus.mul_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 50; i++) begin
      if (!bus.mul_busy_o) break;
      cyc();
    end
    check(name, 64'(bus.mul_busy_o), 64'd0);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (bus.mul_res_valid_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: got result %h tag %0d, expected no result",
                   bus.mul_res_o, bus.mul_res_tag_o);
        end else begin
          check("sb_res", bus.mul_res_o, exp_q[0][63:0]);
          check("sb_tag", 64'(bus.mul_res_tag_o), 64'(exp_q[0][TAG_W+63:64]));
          if (bus.mul_res_ready_i) void'(exp_q.pop_front());
        end
      end
      if (bus.flush_i) exp_q.delete();
      if (bus.mul_valid_i && bus.mul_ready_o && !bus.flush_i)
        exp_q.push_back({bus.mul_tag_i, model(64, bus.opr_a_i, bus.opr_b_i,
                                              bus.mul_func_i, bus.word_op_i)});
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- stimulus ----------------
  logic [63:0] t1_exp[4];
  logic [63:0] va[8], vb[8];
  logic [3:0]  vf[8];
  logic        vw[8];
  logic [31:0] a32[4], b32[4];
  logic [3:0]  f32[4];

  initial begin
    t1_exp = '{64'd15, 64'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
    va = '{64'd123456789, -64'sd7, 64'h8000_0000_0000_0000, 64'hDEAD_BEEF_CAFE_BABE,
           -64'sd5, 64'h7FFF_FFFF_FFFF_FFFF, 64'hABCD_0000_FFFF_FFFF, 64'd0};
    vb = '{64'd987654321, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0,
           64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 64'd5};
    vf = '{FN_MUL, FN_MULH, FN_MUL, FN_MULHU, FN_MULHSU, FN_MULH, FN_MUL, FN_MULHU};
    vw = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    a32 = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    b32 = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    f32 = '{FN_MULH, FN_MUL, FN_MULHSU, FN_MULHU};

    // Model pins: hand-computed products.
    check("pin_mul", model(64, 64'd3, 64'd5, FN_MUL, 1'b0), 64'd15);
    check("pin_mulhu", model(64, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, FN_MULHU, 1'b0), 64'd1);
    check("pin_mulh_m1", model(64, '1, '1, FN_MULH, 1'b0), 64'd0);
    check("pin_mulhsu", model(64, '1, 64'd2, FN_MULHSU, 1'b0), 64'hFFFF_FFFF_FFFF_FFFF);
    check("pin_mulh_min", model(64, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                                FN_MULH, 1'b0), 64'h4000_0000_0000_0000);
    check("pin_mulh_max", model(64, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                                FN_MULH, 1'b0), 64'h3FFF_FFFF_FFFF_FFFF);
    // Low word of -2^31 * 2 = -2^32 is zero, so the sign-extended word is 0.
    check("pin_mulw_min", model(64, 64'h0000_0001_8000_0000, 64'd2, FN_MUL, 1'b1), 64'd0);
    check("pin_mulw_neg", model(64, 64'h0000_0000_7FFF_FFFF, 64'd2, FN_MUL, 1'b1),
          64'hFFFF_FFFF_FFFF_FFFE);
    check("pin_mulh32", model(32, 64'h8000_0000, 64'hFFFF_FFFF, FN_MULH, 1'b0), 64'd0);
    check("pin_mul32", model(32, 64'h8000_0000, 64'hFFFF_FFFF, FN_MUL, 1'b0), 64'h8000_0000);
    check("pin_badfunc", model(64, 64'd3, 64'd5, 4'd9, 1'b0), 64'd0);

    // Reset state
    reset = 1'b1;
    idle();
    bus.opr_a_i = '0; bus.opr_b_i = '0; bus.mul_func_i = '0; bus.word_op_i = 1'b0;
    bus.mul_tag_i = '0; bus.flush_i = 1'b0; bus.mul_res_ready_i = 1'b1;
    bus32.opr_a_i = '0; bus32.opr_b_i = '0; bus32.mul_func_i = '0; bus32.word_op_i = 1'b0;
    bus32.mul_tag_i = '0; bus32.mul_valid_i = 1'b0; bus32.flush_i = 1'b0;
    bus32.mul_res_ready_i = 1'b1;
    repeat (3) cyc();
    @(negedge clk);
    check("rst_ready", 64'(bus.mul_ready_o), 64'd0);
    check("rst_valid", 64'(bus.mul_res_valid_o), 64'd0);
    check("rst_busy", 64'(bus.mul_busy_o), 64'd0);
    check("rst_res", bus.mul_res_o, 64'd0);
    check("rst_tag", 64'(bus.mul_res_tag_o), 64'd0);
    check("rst_ready32", 64'(bus32.mul_ready_o), 64'd0);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(bus.mul_ready_o), 64'd1);
    cyc();

    // Back-to-back issue, results in cycles 4..7
    drive(64'd3, 64'd5, FN_MUL, 1'b0, 5'd1); cyc();
    drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, FN_MULHU, 1'b0, 5'd2); cyc();
    drive('1, '1, FN_MULH, 1'b0, 5'd3); cyc();
    drive('1, 64'd2, FN_MULHSU, 1'b0, 5'd4);
    @(negedge clk);
    check("lat_early", 64'(bus.mul_res_valid_o), 64'd0);
    cyc();
    idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b_valid", 64'(bus.mul_res_valid_o), 64'd1);
      check("b2b_res", bus.mul_res_o, t1_exp[i]);
      check("b2b_tag", 64'(bus.mul_res_tag_o), 64'(i + 1));
      cyc();
    end
    @(negedge clk);
    check("b2b_after", 64'(bus.mul_res_valid_o), 64'd0);
    check("b2b_idle", 64'(bus.mul_busy_o), 64'd0);

    // Boundary operands, word ops, illegal func code
    cyc();
    drive(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, FN_MULH, 1'b0, 5'd5); cyc();
    drive(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, FN_MUL, 1'b0, 5'd6); cyc();
    drive(64'h0000_0001_8000_0000, 64'd2, FN_MUL, 1'b1, 5'd7); cyc();
    drive(64'h0000_0000_7FFF_FFFF, 64'd2, FN_MUL, 1'b1, 5'd8); cyc();
    drive(64'hFFFF_FFFF_0000_0003, 64'h1234_5678_0000_0005, FN_MUL, 1'b1, 5'd9); cyc();
    drive(64'd3, 64'd5, 4'd9, 1'b0, 5'd10); cyc();
    idle();
    wait_drain("drain_bound");

    // Backpressure with four in flight
    bus.mul_res_ready_i = 1'b0;
    drive(64'd7, 64'd6, FN_MUL, 1'b0, 5'd10); cyc();
    drive('1, '1, FN_MULHU, 1'b0, 5'd11); cyc();
    drive(-64'sd3, 64'd4, FN_MUL, 1'b0, 5'd12); cyc();
    drive(64'h4000_0000_0000_0000, 64'd4, FN_MULH, 1'b0, 5'd13); cyc();
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ready", 64'(bus.mul_ready_o), 64'd0);
      check("bp_valid", 64'(bus.mul_res_valid_o), 64'd1);
      check("bp_res", bus.mul_res_o, 64'd42);
      check("bp_tag", 64'(bus.mul_res_tag_o), 64'd10);
      check("bp_busy", 64'(bus.mul_busy_o), 64'd1);
      cyc();
    end
    bus.mul_res_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_drain_valid", 64'(bus.mul_res_valid_o), 64'd1);
      check("bp_drain_tag", 64'(bus.mul_res_tag_o), 64'(10 + i));
      cyc();
    end
    @(negedge clk);
    check("bp_done", 64'(bus.mul_res_valid_o), 64'd0);

    // Flush with three in flight and a request in the flush cycle
    cyc();
    drive(64'd2, 64'd3, FN_MUL, 1'b0, 5'd20); cyc();
    drive(64'd4, 64'd5, FN_MUL, 1'b0, 5'd21); cyc();
    drive(64'd6, 64'd7, FN_MUL, 1'b0, 5'd22); cyc();
    drive(64'd8, 64'd9, FN_MUL, 1'b0, 5'd23);
    bus.flush_i = 1'b1;
    cyc();
    bus.flush_i = 1'b0;
    drive(64'd9, 64'd9, FN_MUL, 1'b0, 5'd24);
    @(negedge clk);
    check("fl_busy", 64'(bus.mul_busy_o), 64'd0);
    cyc();
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("fl_quiet", 64'(bus.mul_res_valid_o), 64'd0);
      cyc();
    end
    @(negedge clk);
    check("fl_new_valid", 64'(bus.mul_res_valid_o), 64'd1);
    check("fl_new_res", bus.mul_res_o, 64'd81);
    check("fl_new_tag", 64'(bus.mul_res_tag_o), 64'd24);
    cyc();

    // Flush beats a ready consumer: result dropped
    drive(64'd11, 64'd11, FN_MUL, 1'b0, 5'd25); cyc();
    idle();
    repeat (3) cyc();
    bus.flush_i = 1'b1;
    @(negedge clk);
    check("flw_valid", 64'(bus.mul_res_valid_o), 64'd0);
    check("flw_busy", 64'(bus.mul_busy_o), 64'd1);
    cyc();
    bus.flush_i = 1'b0;
    @(negedge clk);
    check("flw_after_busy", 64'(bus.mul_busy_o), 64'd0);
    check("flw_after_valid", 64'(bus.mul_res_valid_o), 64'd0);
    cyc();

    // Reset mid-operation discards everything
    drive(64'd13, 64'd2, FN_MUL, 1'b0, 5'd26); cyc();
    drive(64'd14, 64'd2, FN_MUL, 1'b0, 5'd27); cyc();
    idle();
    reset = 1'b1;
    cyc();
    @(negedge clk);
    check("mr_ready", 64'(bus.mul_ready_o), 64'd0);
    check("mr_busy", 64'(bus.mul_busy_o), 64'd0);
    check("mr_res", bus.mul_res_o, 64'd0);
    check("mr_tag", 64'(bus.mul_res_tag_o), 64'd0);
    cyc();
    reset = 1'b0;
    repeat (6) cyc();
    check("mr_quiet", 64'(bus.mul_busy_o), 64'd0);

    // Mixed vectors under intermittent backpressure
    for (int i = 0; i < 8; i++) begin
      drive(va[i], vb[i], vf[i], vw[i], 5'(i));
      for (int k = 0; k < 20; k++) begin
        bus.mul_res_ready_i = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (bus.mul_ready_o) begin
          cyc();
          break;
        end
        cyc();
      end
    end
    idle();
    bus.mul_res_ready_i = 1'b1;
    wait_drain("drain_mixed");
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    // 32-bit build: word_op_i set but ignored
    for (int i = 0; i < 4; i++) begin
      bus32.opr_a_i = a32[i]; bus32.opr_b_i = b32[i]; bus32.mul_func_i = f32[i];
      bus32.word_op_i = 1'b1; bus32.mul_tag_i = 5'(i + 3); bus32.mul_valid_i = 1'b1;
      cyc();
    end
    bus32.mul_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("x32_valid", 64'(bus32.mul_res_valid_o), 64'd1);
      check("x32_res", 64'(bus32.mul_res_o),
            model(32, 64'(a32[i]), 64'(b32[i]), f32[i], 1'b0));
      check("x32_tag", 64'(bus32.mul_res_tag_o), 64'(i + 3));
      if (i == 0) check("x32_mulh_lit", 64'(bus32.mul_res_o), 64'h0000_0000);
      if (i == 1) check("x32_mul_lit", 64'(bus32.mul_res_o), 64'h8000_0000);
      cyc();
    end
    @(negedge clk);
    check("x32_done", 64'(bus32.mul_busy_o), 64'd0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
